// File: rtl/slice_reassembler.sv
`timescale 1ns/1ps
// Purpose : rebuilds WORD_W-bit words from SLICE_W-bit slices (slice 0 = LSBs), checks framing, counts errored words.
// Latency : m_valid rises one cycle after the completing slice is accepted.
// Backpressure: non-final slices are always taken; a completing slice waits until the output register is free or draining.
//
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last - slice input stream (s_par: odd parity, only with SLICE_REASM_PARITY_EN)
//   m_valid/m_ready/m_data/m_err  - reassembled word output stream, m_err flags framing/parity error
//   err_cnt                    - saturating count of errored words loaded into the output register
// Build option: define SLICE_REASM_PARITY_EN to add the s_par input and per-beat odd-parity checking.
module slice_reassembler #(
  parameter int SLICE_W    = 12,
  parameter int NUM_SLICES = 3,
  parameter int WORD_W     = 41,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [SLICE_W-1:0]   s_data,
  input  logic                 s_last,
`ifdef SLICE_REASM_PARITY_EN
  input  logic                 s_par,
`endif
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_W-1:0]    m_data,
  output logic                 m_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int ASM_W = NUM_SLICES * SLICE_W;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_RESYNC  = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [ASM_W-1:0]       r_asm, w_asm_nxt, w_asm_ins;
  logic                   r_m_valid;
  logic [WORD_W-1:0]      r_m_data;
  logic                   r_m_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_accept;
  logic                   w_at_last;
  logic                   w_complete;
  logic                   w_load;
  logic                   w_load_err;
  logic                   w_word_perr;
  logic [WORD_W-1:0]      w_word;

  assign w_at_last = (r_idx == LAST_IDX);

  // Only a beat that could finish a word (last index or s_last) needs the
  // output register; everything else, and every discarded beat, flows freely.
  assign s_ready  = (r_state == ST_RESYNC) || (!w_at_last && !s_last) || !r_m_valid || m_ready;
  assign w_accept = s_valid && s_ready;
  assign w_complete = w_accept && (r_state == ST_COLLECT) && (w_at_last || s_last);

`ifdef SLICE_REASM_PARITY_EN
  logic r_perr;
  logic w_beat_perr;

  assign w_beat_perr = ~(^{s_data, s_par});
  // Include the current beat so a bad final slice is flagged in its own word.
  assign w_word_perr = r_perr | w_beat_perr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (w_accept && (r_state == ST_COLLECT)) begin
      r_perr <= w_complete ? 1'b0 : w_word_perr;
    end
  end
`else
  assign w_word_perr = 1'b0;
`endif

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_asm_nxt   = r_asm;
    w_load      = 1'b0;
    w_load_err  = 1'b0;

    // Current assembly with the presented slice dropped into its lane.
    w_asm_ins = r_asm;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_asm_ins[i*SLICE_W +: SLICE_W] = s_data;
      end
    end
    // Bits above the slice lanes are always zero.
    w_word = WORD_W'(w_asm_ins);

    case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
          if (w_at_last || s_last) begin
            w_load     = 1'b1;
            // Clean only when the last lane and s_last coincide.
            w_load_err = !(w_at_last && s_last) || w_word_perr;
            w_idx_nxt  = '0;
            w_asm_nxt  = '0;
            if (!s_last) begin
              w_state_nxt = ST_RESYNC;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            w_asm_nxt = w_asm_ins;
          end
        end
      end
      ST_RESYNC: begin
        w_idx_nxt = '0;
        if (w_accept && s_last) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_COLLECT;
      r_idx     <= '0;
      r_asm     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_err   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_asm   <= w_asm_nxt;

      // A load while draining keeps m_valid high with the new word.
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_word;
        r_m_err   <= w_load_err;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (w_load && w_load_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_err   = r_m_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: doc/slice_reassembler.md
# slice_reassembler

Receive-side counterpart of the 41-bit lane splitter. Accepts 12-bit slices one beat at a time over a valid/ready stream and reassembles them into full 41-bit words, slice 0 holding bits [11:0]. Sits at the far end of the sliced A/B/C lane path: slices leave the split-lane logic serially, and this block rebuilds the word for the wide consumer. Also checks framing and keeps a saturating error count.

## Interface
- SLICE_W, 12, width of one slice
- NUM_SLICES, 3, slices per word (≥ 2)
- WORD_W, 41, output word width; must be ≥ NUM_SLICES*SLICE_W
- ERR_CNT_W, 8, width of error counter
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset
- s_valid  input  1  slice beat valid
- s_ready  output  1  block accepts beat this cycle
- s_data  input  SLICE_W  slice payload
- s_last  input  1  marks final slice of a word
- s_par  input  1  odd parity bit for s_data (present only with SLICE_REASM_PARITY_EN)
- m_valid  output  1  reassembled word valid
- m_ready  input  1  downstream accepts word
- m_data  output  WORD_W  reassembled word
- m_err  output  1  word carries framing or parity error
- err_cnt  output  ERR_CNT_W  saturating count of errored words

## Operation
- Beat accepted when s_valid && s_ready. Word emitted when m_valid && m_ready.
- Slice index idx counts 0..NUM_SLICES-1. Accepted slice goes to assembly register bits [idx*SLICE_W +: SLICE_W]. Bits [WORD_W-1 : NUM_SLICES*SLICE_W] are always 0 (bits 40:36 at defaults).
- States:
  - COLLECT (reset state): normal assembly.
  - RESYNC: discards beats until s_last.
- COLLECT, completing beat: a beat is completing when idx==NUM_SLICES-1 or s_last=1. On a completing beat:
  - the word moves to the output register and m_valid is set;
  - idx returns to 0;
  - the assembly register clears.
- Early s_last (idx < NUM_SLICES-1): slices not yet received read 0, and m_err=1.
- Final slice with s_last=0: the word is emitted with m_err=1, and the state moves to RESYNC.
- RESYNC: s_ready=1. Beats are dropped. An accepted beat with s_last=1 returns to COLLECT with idx=0.
- s_ready = (state==RESYNC) || (idx != NUM_SLICES-1 && !s_last_pending) || !m_valid || m_ready. Non-final slices are always accepted. A beat that may complete a word is accepted only if the output register is free or draining this cycle. s_ready therefore depends combinationally on m_ready and on s_last of the presented beat.
- err_cnt increments by 1 each time an errored word is loaded into the output register, and saturates at all-ones.
- m_data and m_err hold stable while m_valid && !m_ready.

## Timing
- Latency: m_valid rises the cycle after the completing beat is accepted.
- Throughput: one slice per cycle. A word is emitted every NUM_SLICES cycles with no bubble when m_ready is held high.
- Simultaneous events: if a word is emitted and a new completing beat is accepted in the same cycle, the output register reloads and m_valid stays 1.
- Reset (rst_n=0 at a clock edge), including mid-word: the partial word is discarded.
  - Outputs: m_valid=0, m_data=0, m_err=0, err_cnt=0.
  - Internal: idx=0, state=COLLECT.
  - s_ready=1 from the first cycle after reset.

## Configuration
- SLICE_REASM_PARITY_EN defined:
  - s_par port exists.
  - Each accepted beat must satisfy ^{s_data,s_par}==1.
  - A mismatch sets a sticky per-word error flag. The word is still assembled and emitted with m_err=1 and counted once in err_cnt. Framing handling is unchanged.
- SLICE_REASM_PARITY_EN undefined: no s_par port, no parity logic; m_err reflects framing errors only.

## Test plan
- Normal word: beats 0xABC, 0x123, 0x456 (s_last on third), m_ready=1. Required: m_data=41'h0_456123ABC, m_err=0, m_valid one cycle after third beat, err_cnt=0.
- Back-to-back: 4 words streamed with s_valid=1 continuously. Required: s_ready never drops, m_valid pulses every 3 cycles, data in order.
- Backpressure: m_ready=0 with one word held; send 2 slices of next word then a third. Required: first two accepted; third stalls (s_ready=0) until m_ready=1; held m_data unchanged throughout.
- Early s_last: 0x111 then 0x222 with s_last. Required: m_data=41'h0_000222111, m_err=1, err_cnt=1.
- Missing s_last: 3 beats with no s_last, then 0x777 and 0x888 (s_last), then a clean word. Required: first word m_err=1; 0x777/0x888 dropped; clean word m_err=0.
- Reset mid-word and parity: with SLICE_REASM_PARITY_EN, one slice with bad parity, then rst_n=0 after the second slice. Required: no word emitted; all outputs 0; next clean word correct. Without reset, the bad-parity word has m_err=1.
